// File: rtl/decomp16_arbiter_pkg.sv
// rtl/decomp16_arbiter_pkg.sv - FP32 field layout, signed-zero constants and channel type
package decomp16_arbiter_pkg;

  localparam int FP_SIGN_W = 1;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int FP_W      = FP_SIGN_W + FP_EXP_W + FP_MANT_W;

  localparam logic [FP_EXP_W-1:0] FP_EXP_BIAS = 8'd127;
  localparam logic [FP_W-1:0]     FP_POS_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0]     FP_NEG_ZERO = 32'h8000_0000;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } chan_t;

  function automatic logic [FP_W-1:0] signed_zero(input logic sign);
    return sign ? FP_NEG_ZERO : FP_POS_ZERO;
  endfunction

endpackage

// File: rtl/decomp16_arbiter_decomp.sv
// rtl/decomp16_arbiter_decomp.sv - decompressor_16: sign + 15-bit fraction to FP32
// Magnitude is a Q0.15 fraction; an all-zero magnitude encodes full scale (1.0).
module decompressor_16
  import decomp16_arbiter_pkg::*;
(
  input  logic [15:0]     data_i,
  output logic [FP_W-1:0] data_o
);

  logic [3:0]           lead;
  logic [FP_EXP_W-1:0]  exp_f;
  logic [FP_MANT_W-1:0] mant_f;

  always_comb begin
    lead = '0;
    for (int i = 0; i < 15; i++) begin
      if (data_i[i]) lead = 4'(i);
    end
    if (data_i[14:0] == 15'd0) begin
      exp_f  = FP_EXP_BIAS;
      mant_f = '0;
    end else begin
      exp_f  = FP_EXP_BIAS - 8'd15 + {4'b0, lead};
      // Shifting the leading one to bit 23 pushes it out, leaving the fraction bits.
      mant_f = {8'b0, data_i[14:0]} << (5'd23 - {1'b0, lead});
    end
  end

  assign data_o = {data_i[15], exp_f, mant_f};

endmodule

// File: rtl/decomp16_arbiter.sv
// rtl/decomp16_arbiter.sv - two-channel round-robin front end sharing one decompressor_16
module decomp16_arbiter
  import decomp16_arbiter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [15:0]      s0_data,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic [15:0]      s1_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [FP_W-1:0]  m_data,
  output logic             m_chan,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic             m_valid_q, m_valid_d;
  logic [FP_W-1:0]  m_data_q, m_data_d;
  chan_t            m_chan_q, m_chan_d;
  chan_t            last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  chan_t            grant;
  logic             can_accept, sel_valid, accept;
  logic [15:0]      sel_data;
  logic [FP_W-1:0]  dec_out, result;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Contention goes to whichever channel did not win the last completed transfer.
  always_comb begin
    grant = last_grant_q;
    if (s0_valid && s1_valid) begin
      grant = (last_grant_q == CH0) ? CH1 : CH0;
    end else if (s0_valid) begin
      grant = CH0;
    end else if (s1_valid) begin
      grant = CH1;
    end
  end

  assign can_accept = !m_valid_q || m_ready;
  assign s0_ready   = rst_n && can_accept && (grant == CH0);
  assign s1_ready   = rst_n && can_accept && (grant == CH1);
  assign sel_data   = (grant == CH1) ? s1_data : s0_data;
  assign sel_valid  = (grant == CH1) ? s1_valid : s0_valid;
  assign accept     = sel_valid && can_accept && rst_n;

  decompressor_16 u_decomp (
    .data_i (sel_data),
    .data_o (dec_out)
  );

  assign result = (ZERO_BYPASS && (sel_data[14:0] == 15'd0)) ? signed_zero(sel_data[15]) : dec_out;

  always_comb begin
    m_valid_d    = m_valid_q && !m_ready;
    m_data_d     = m_data_q;
    m_chan_d     = m_chan_q;
    last_grant_d = last_grant_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    if (accept) begin
      m_valid_d    = 1'b1;
      m_data_d     = result;
      m_chan_d     = grant;
      last_grant_d = grant;
      if (grant == CH1) cnt1_d = cnt1_q + CNT_ONE;
      else              cnt0_d = cnt0_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_chan_q     <= CH0;
      last_grant_q <= CH1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_chan_q     <= m_chan_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_chan  = m_chan_q;
  assign cnt0    = cnt0_q;
  assign cnt1    = cnt1_q;

endmodule

// File: tb/tb_decomp16_arbiter.sv
// tb/tb_decomp16_arbiter.sv - self-checking bench for decomp16_arbiter
module tb_decomp16_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s0_valid = 1'b0, s1_valid = 1'b0, m_ready = 1'b0;
  logic [15:0] s0_data = '0, s1_data = '0;

  logic        s0_ready, s1_ready, m_valid, m_chan;
  logic [31:0] m_data;
  logic [3:0]  cnt0, cnt1;
  logic        s0_ready_nb, s1_ready_nb, m_valid_nb, m_chan_nb;
  logic [31:0] m_data_nb;
  logic [15:0] cnt0_nb, cnt1_nb;

  int checks = 0;
  int errors = 0;

  bit          e_valid;
  logic [31:0] e_data, e_data_nb;
  bit          e_chan, e_last;
  int unsigned e_cnt0, e_cnt1;

  decomp16_arbiter #(.CNT_W(4), .ZERO_BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  decomp16_arbiter #(.CNT_W(16), .ZERO_BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready_nb), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready_nb), .s1_data(s1_data),
    .m_valid(m_valid_nb), .m_ready(m_ready), .m_data(m_data_nb), .m_chan(m_chan_nb),
    .cnt0(cnt0_nb), .cnt1(cnt1_nb)
  );

  initial forever #5 clk = ~clk;

  // Reference value via real arithmetic: magnitude/2^15, zero magnitude = 1.0.
  function automatic logic [31:0] ref_fp(input logic [15:0] w, input bit zb);
    real v;
    logic [63:0] b;
    if (w[14:0] == 15'd0) begin
      if (zb) return {w[15], 31'b0};
      v = 1.0;
    end else begin
      v = real'(int'(w[14:0])) / 32768.0;
    end
    b = $realtobits(v);
    return {w[15], 8'(b[62:52] - 11'd896), b[51:29]};
  endfunction

  function automatic void model_reset();
    e_valid = 0; e_data = '0; e_data_nb = '0; e_chan = 0; e_last = 1;
    e_cnt0 = 0; e_cnt1 = 0;
  endfunction

  function automatic void model_ready(output bit r0, output bit r1, output bit g);
    bit ca;
    ca = !e_valid || m_ready;
    if (s0_valid && s1_valid) g = !e_last;
    else if (s0_valid)        g = 0;
    else if (s1_valid)        g = 1;
    else                      g = e_last;
    r0 = ca && !g;
    r1 = ca && g;
  endfunction

  task automatic drive(input logic v0, input logic [15:0] d0, input logic v1,
                       input logic [15:0] d1, input logic rdy);
    s0_valid = v0; s0_data = d0; s1_valid = v1; s1_data = d1; m_ready = rdy;
  endtask

  task automatic tick();
    bit r0, r1, g, acc, rdy;
    logic [15:0] w;
    model_ready(r0, r1, g);
    acc = g ? (s1_valid && r1) : (s0_valid && r0);
    w   = g ? s1_data : s0_data;
    rdy = m_ready;
    @(posedge clk);
    if (acc) begin
      e_valid = 1; e_data = ref_fp(w, 1); e_data_nb = ref_fp(w, 0);
      e_chan = g; e_last = g;
      if (g) e_cnt1++; else e_cnt0++;
    end else if (rdy) begin
      e_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    drive(0, '0, 0, '0, 0);
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive(1, 16'h1234, 1, 16'h5678, 1);
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_m_data: got %h expected 0", m_data); end
    checks++; if (m_chan !== 1'b0) begin errors++; $display("FAIL reset_m_chan: got %b expected 0", m_chan); end
    checks++; if (cnt0 !== 4'd0 || cnt1 !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt0, cnt1); end
    checks++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b expected 00", s0_ready, s1_ready); end
    @(posedge clk);
    #1;
    checks++; if (m_valid !== 1'b0 || s0_ready !== 1'b0) begin errors++; $display("FAIL reset_held: got valid %b ready %b expected 0 0", m_valid, s0_ready); end
  endtask

  task automatic test_single_word();
    do_reset();
    drive(1, 16'h4000, 0, 16'h0, 1);
    #1;
    checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin errors++; $display("FAIL single_ready: got %b%b expected 10", s0_ready, s1_ready); end
    tick();
    drive(0, '0, 0, '0, 1);
    #1;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", m_valid); end
    checks++; if (m_data !== 32'h3F00_0000) begin errors++; $display("FAIL single_data: got %h expected 3f000000", m_data); end
    checks++; if (m_chan !== 1'b0) begin errors++; $display("FAIL single_chan: got %b expected 0", m_chan); end
    checks++; if (cnt0 !== 4'd1 || cnt1 !== 4'd0) begin errors++; $display("FAIL single_cnt: got %0d/%0d expected 1/0", cnt0, cnt1); end
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", m_valid); end
  endtask

  task automatic test_contention();
    logic [31:0] want;
    do_reset();
    drive(1, 16'h6000, 1, 16'hC000, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      want = (i % 2 == 0) ? 32'h3F40_0000 : 32'hBF00_0000;
      checks++;
      if (m_valid !== 1'b1 || m_data !== want || m_chan !== 1'(i % 2)) begin
        errors++;
        $display("FAIL contention_%0d: got v%b %h ch%b expected v1 %h ch%0d", i, m_valid, m_data, m_chan, want, i % 2);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1, 16'h6000, 1, 16'hC000, 1);
    tick();
    m_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (s0_ready !== 1'b0 || s1_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 32'h3F40_0000) begin
        errors++;
        $display("FAIL stall_%0d: got rdy %b%b v%b %h expected rdy 00 v1 3f400000", i, s0_ready, s1_ready, m_valid, m_data);
      end
      tick();
    end
    checks++; if (cnt1 !== 4'd0) begin errors++; $display("FAIL stall_cnt1: got %0d expected 0", cnt1); end
    m_ready = 1;
    #1;
    checks++; if (s1_ready !== 1'b1 || s0_ready !== 1'b0) begin errors++; $display("FAIL release_ready: got %b%b expected 01", s0_ready, s1_ready); end
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'hBF00_0000 || m_chan !== 1'b1) begin
      errors++;
      $display("FAIL release_data: got v%b %h ch%b expected v1 bf000000 ch1", m_valid, m_data, m_chan);
    end
  endtask

  task automatic test_zero_bypass();
    do_reset();
    drive(0, '0, 1, 16'h8000, 1);
    tick();
    checks++; if (m_data !== 32'h8000_0000) begin errors++; $display("FAIL zb_neg_zero: got %h expected 80000000", m_data); end
    checks++; if (m_data_nb !== 32'hBF80_0000) begin errors++; $display("FAIL nozb_neg: got %h expected bf800000", m_data_nb); end
    drive(0, '0, 1, 16'h0000, 1);
    tick();
    checks++; if (m_data !== 32'h0 || m_chan !== 1'b1) begin errors++; $display("FAIL zb_pos_zero: got %h ch%b expected 0 ch1", m_data, m_chan); end
    checks++; if (m_data_nb !== 32'h3F80_0000) begin errors++; $display("FAIL nozb_pos: got %h expected 3f800000", m_data_nb); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 16'($urandom), 0, '0, 1);
      tick();
    end
    checks++; if (cnt0 !== 4'd1 || cnt1 !== 4'd0) begin errors++; $display("FAIL wrap_cnt: got %0d/%0d expected 1/0", cnt0, cnt1); end
    checks++; if (cnt0_nb !== 16'd17) begin errors++; $display("FAIL wrap_cnt_wide: got %0d expected 17", cnt0_nb); end
  endtask

  task automatic test_random();
    bit r0, r1, g;
    logic [15:0] d0, d1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      d0 = 16'($urandom); d1 = 16'($urandom);
      if ($urandom_range(7) == 0) d0[14:0] = '0;
      if ($urandom_range(7) == 0) d1[14:0] = '0;
      drive(1'($urandom), d0, 1'($urandom), d1, ($urandom_range(3) != 0));
      #1;
      model_ready(r0, r1, g);
      checks++;
      if (s0_ready !== r0 || s1_ready !== r1 || s0_ready_nb !== r0 || s1_ready_nb !== r1) begin
        errors++;
        $display("FAIL rand_ready_%0d: got %b%b/%b%b expected %b%b", i, s0_ready, s1_ready, s0_ready_nb, s1_ready_nb, r0, r1);
      end
      checks++;
      if (m_valid !== e_valid || m_data !== e_data || m_chan !== e_chan || m_valid_nb !== e_valid
          || m_data_nb !== e_data_nb || m_chan_nb !== e_chan) begin
        errors++;
        $display("FAIL rand_out_%0d: got v%b %h ch%b nb %h expected v%b %h ch%b nb %h", i, m_valid, m_data, m_chan,
                 m_data_nb, e_valid, e_data, e_chan, e_data_nb);
      end
      checks++;
      if (cnt0 !== 4'(e_cnt0) || cnt1 !== 4'(e_cnt1) || cnt0_nb !== 16'(e_cnt0) || cnt1_nb !== 16'(e_cnt1)) begin
        errors++;
        $display("FAIL rand_cnt_%0d: got %0d/%0d %0d/%0d expected %0d/%0d", i, cnt0, cnt1, cnt0_nb, cnt1_nb, e_cnt0, e_cnt1);
      end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    drive(1, 16'h4000, 0, '0, 0);
    tick();
    drive(0, '0, 0, '0, 0);
    #1;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", m_valid); end
    #2 rst_n = 0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 32'h0 || cnt0 !== 4'd0) begin
      errors++;
      $display("FAIL mid_async: got v%b %h cnt0 %0d expected v0 0 cnt0 0", m_valid, m_data, cnt0);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    drive(1, 16'h6000, 1, 16'hC000, 1);
    #1;
    checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin errors++; $display("FAIL mid_grant: got %b%b expected 10", s0_ready, s1_ready); end
    tick();
    checks++; if (m_chan !== 1'b0 || m_data !== 32'h3F40_0000) begin errors++; $display("FAIL mid_first: got ch%b %h expected ch0 3f400000", m_chan, m_data); end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_single_word();
    test_contention();
    test_backpressure();
    test_zero_bypass();
    test_counter_wrap();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
